// File: rtl/decode_control_pipe.sv
// Decode-to-execute control pipeline stage. Decodes the RV32I (and, when
// enabled, RV32M) control word from InstrD and registers it into the E slot.
// Multi-cycle M ops hold the E slot for MULDIV_CYCLES cycles and stall decode.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | E slot advances every non-stalled cycle; new InstrD accepted
// BUSY  | M op occupying E; E held, counter counts remaining cycles
module decode_control_pipe #(
   parameter bit EN_MEXT       = 1'b0,
   parameter int MULDIV_CYCLES = 4,
   parameter int ALU_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      InstrD,
   input  logic             ValidD,
   input  logic             StallE,
   input  logic             FlushE,
   output logic             StallD,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic             JumpE,
   output logic             BranchE,
   output logic             AluSrcE,
   output logic [1:0]       ResultSrcE,
   output logic [2:0]       ImmSrcE,
   output logic [ALU_W-1:0] ALUControlE,
   output logic             ValidE,
   output logic             IllegalE
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_XOR   = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd3;
   localparam logic [4:0] ALU_AND   = 5'd4;
   localparam logic [4:0] ALU_SLL   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_SLT   = 5'd8;
   localparam logic [4:0] ALU_SLTU  = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;
   localparam logic [4:0] ALU_MBASE = 5'd16;

   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;
   localparam logic [2:0] IMM_S    = 3'b001;
   localparam logic [2:0] IMM_B    = 3'b010;
   localparam logic [2:0] IMM_J    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;

   localparam logic [4:0] CNT_INIT = 5'(MULDIV_CYCLES - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic       load_e, flush_e;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_instr_bits;

   logic       d_rw, d_mw, d_j, d_b, d_as, d_ill, d_is_m;
   logic [1:0] d_rs;
   logic [2:0] d_imm;
   logic [4:0] d_alu;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign funct7 = InstrD[31:25];
   assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

   // funct3 -> ALU op for register and immediate ALU groups; alt picks sub/sra
   function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
      logic [4:0] code;
      code = ALU_ADD;
      case (f3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   // Combinational decode of InstrD; illegal encodings leave every enable at 0
   always_comb begin
      d_rw   = 1'b0;
      d_mw   = 1'b0;
      d_j    = 1'b0;
      d_b    = 1'b0;
      d_as   = 1'b0;
      d_rs   = 2'b00;
      d_imm  = 3'b000;
      d_alu  = ALU_ADD;
      d_ill  = 1'b0;
      d_is_m = 1'b0;
      if (ValidD) begin
         case (opcode)
            OP_R: begin
               if (funct7 == 7'b0000000) begin
                  d_rw  = 1'b1;
                  d_alu = alu_f3(funct3, 1'b0);
               end else if (funct7 == 7'b0100000 &&
                            (funct3 == 3'b000 || funct3 == 3'b101)) begin
                  d_rw  = 1'b1;
                  d_alu = alu_f3(funct3, 1'b1);
               end else if (funct7 == 7'b0000001 && EN_MEXT) begin
                  d_rw   = 1'b1;
                  d_alu  = ALU_MBASE + {2'b00, funct3};
                  d_is_m = 1'b1;
               end else begin
                  d_ill = 1'b1;
               end
            end
            OP_IALU: begin
               // shift-immediates carry their variant in funct7 bits
               if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                   (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
                  d_ill = 1'b1;
               end else begin
                  d_rw  = 1'b1;
                  d_as  = 1'b1;
                  d_alu = alu_f3(funct3, (funct3 == 3'b101) && funct7[5]);
               end
            end
            OP_LOAD: begin
               d_rw = 1'b1;
               d_as = 1'b1;
               d_rs = RES_MEM;
            end
            OP_STORE: begin
               d_mw  = 1'b1;
               d_as  = 1'b1;
               d_imm = IMM_S;
            end
            OP_BRANCH: begin
               d_b   = 1'b1;
               d_imm = IMM_B;
               d_alu = ALU_SUB;
            end
            OP_JAL: begin
               d_j   = 1'b1;
               d_rw  = 1'b1;
               d_rs  = RES_PC4;
               d_imm = IMM_J;
            end
            OP_JALR: begin
               if (funct3 == 3'b000) begin
                  d_j  = 1'b1;
                  d_rw = 1'b1;
                  d_as = 1'b1;
                  d_rs = RES_PC4;
               end else begin
                  d_ill = 1'b1;
               end
            end
            OP_LUI: begin
               d_rw  = 1'b1;
               d_as  = 1'b1;
               d_imm = IMM_U;
               d_alu = ALU_PASSB;
            end
            OP_AUIPC: begin
               d_rw  = 1'b1;
               d_as  = 1'b1;
               d_imm = IMM_U;
            end
            OP_SYSTEM: begin
               d_ill = 1'b0;
            end
            default: d_ill = 1'b1;
         endcase
      end
   end

   // FSM state and occupancy counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: flush beats stall beats load; BUSY counts down to release
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_e  = 1'b0;
      flush_e = 1'b0;
      if (FlushE) begin
         state_d = ST_IDLE;
         cnt_d   = 5'd0;
         flush_e = 1'b1;
      end else if (!StallE) begin
         case (state_q)
            ST_IDLE: begin
               load_e = 1'b1;
               if (d_is_m && (MULDIV_CYCLES > 1)) begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
            default: begin
               if (cnt_q <= 5'd1) begin
                  state_d = ST_IDLE;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         endcase
      end
   end

   assign StallD = StallE || (state_q == ST_BUSY);

   // E-slot control register: bubble on flush, load decoded word when accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ValidE      <= 1'b0;
         IllegalE    <= 1'b0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         AluSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ImmSrcE     <= 3'b000;
         ALUControlE <= '0;
      end else if (flush_e) begin
         ValidE      <= 1'b0;
         IllegalE    <= 1'b0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         AluSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ImmSrcE     <= 3'b000;
         ALUControlE <= '0;
      end else if (load_e) begin
         ValidE      <= ValidD;
         IllegalE    <= d_ill;
         RegWriteE   <= d_rw;
         MemWriteE   <= d_mw;
         JumpE       <= d_j;
         BranchE     <= d_b;
         AluSrcE     <= d_as;
         ResultSrcE  <= d_rs;
         ImmSrcE     <= d_imm;
         ALUControlE <= ALU_W'(d_alu);
      end
   end

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: one M-enabled instance (4-cycle M ops) and
// one base-only instance share stimulus; both are compared every cycle with
// an instruction-level reference model.
module tb_decode_control_pipe;

   typedef struct packed {
      logic       v;
      logic       ill;
      logic       rw;
      logic       mw;
      logic       j;
      logic       b;
      logic       as;
      logic [1:0] rs;
      logic [2:0] imm;
      logic [4:0] alu;
   } ctl_t;

   localparam int CYC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        valid = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   logic       stalld_m, rw_m, mw_m, j_m, b_m, as_m, ve_m, ill_m;
   logic [1:0] rs_m;
   logic [2:0] imm_m;
   logic [4:0] alu_m;
   logic       stalld_i, rw_i, mw_i, j_i, b_i, as_i, ve_i, ill_i;
   logic [1:0] rs_i;
   logic [2:0] imm_i;
   logic [4:0] alu_i;

   ctl_t obs_m, obs_i, exp_m, exp_i;
   int   busy_m, busy_i;
   int   checks = 0;
   int   failures = 0;
   logic sd_m, sd_i;

   always #5 clk = ~clk;

   decode_control_pipe #(.EN_MEXT(1'b1), .MULDIV_CYCLES(CYC), .ALU_W(5)) u_dut_m (
      .clk(clk), .rst_n(rst_n), .InstrD(instr), .ValidD(valid), .StallE(stall), .FlushE(flush),
      .StallD(stalld_m), .RegWriteE(rw_m), .MemWriteE(mw_m), .JumpE(j_m), .BranchE(b_m),
      .AluSrcE(as_m), .ResultSrcE(rs_m), .ImmSrcE(imm_m), .ALUControlE(alu_m),
      .ValidE(ve_m), .IllegalE(ill_m));

   decode_control_pipe #(.EN_MEXT(1'b0), .MULDIV_CYCLES(CYC), .ALU_W(5)) u_dut_i (
      .clk(clk), .rst_n(rst_n), .InstrD(instr), .ValidD(valid), .StallE(stall), .FlushE(flush),
      .StallD(stalld_i), .RegWriteE(rw_i), .MemWriteE(mw_i), .JumpE(j_i), .BranchE(b_i),
      .AluSrcE(as_i), .ResultSrcE(rs_i), .ImmSrcE(imm_i), .ALUControlE(alu_i),
      .ValidE(ve_i), .IllegalE(ill_i));

   assign obs_m = {ve_m, ill_m, rw_m, mw_m, j_m, b_m, as_m, rs_m, imm_m, alu_m};
   assign obs_i = {ve_i, ill_i, rw_i, mw_i, j_i, b_i, as_i, rs_i, imm_i, alu_i};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Instruction-level reference: what the E slot should hold for one word
   function automatic ctl_t ref_decode(input logic [31:0] ins, input logic vld,
                                       input bit mext, output bit is_m);
      int    f3tbl[8] = '{0, 5, 8, 9, 2, 6, 3, 4};
      ctl_t  c;
      bit    bad;
      int    op, f3, f7;
      c    = '0;
      is_m = 0;
      bad  = 0;
      op   = int'(ins[6:0]);
      f3   = int'(ins[14:12]);
      f7   = int'(ins[31:25]);
      if (!vld) return c;
      c.v = 1'b1;
      if (op == 'h33) begin
         if (f7 == 0)                                   c.alu = 5'(f3tbl[f3]);
         else if (f7 == 'h20 && f3 == 0)                c.alu = 5'd1;
         else if (f7 == 'h20 && f3 == 5)                c.alu = 5'd7;
         else if (f7 == 1 && mext) begin                c.alu = 5'(16 + f3); is_m = 1; end
         else bad = 1;
         c.rw = 1'b1;
      end else if (op == 'h13) begin
         if (f3 == 1 && f7 != 0) bad = 1;
         if (f3 == 5 && f7 != 0 && f7 != 'h20) bad = 1;
         c.rw = 1'b1; c.as = 1'b1;
         c.alu = (f3 == 5 && f7 == 'h20) ? 5'd7 : 5'(f3tbl[f3]);
      end else if (op == 'h03) begin
         c.rw = 1'b1; c.as = 1'b1; c.rs = 2'd1;
      end else if (op == 'h23) begin
         c.mw = 1'b1; c.as = 1'b1; c.imm = 3'd1;
      end else if (op == 'h63) begin
         c.b = 1'b1; c.imm = 3'd2; c.alu = 5'd1;
      end else if (op == 'h6F) begin
         c.j = 1'b1; c.rw = 1'b1; c.rs = 2'd2; c.imm = 3'd3;
      end else if (op == 'h67) begin
         if (f3 != 0) bad = 1;
         c.j = 1'b1; c.rw = 1'b1; c.as = 1'b1; c.rs = 2'd2;
      end else if (op == 'h37) begin
         c.rw = 1'b1; c.as = 1'b1; c.imm = 3'd4; c.alu = 5'd10;
      end else if (op == 'h17) begin
         c.rw = 1'b1; c.as = 1'b1; c.imm = 3'd4;
      end else if (op == 'h73) begin
         c.v = 1'b1;
      end else begin
         bad = 1;
      end
      if (bad) begin
         c     = '0;
         c.v   = 1'b1;
         c.ill = 1'b1;
         is_m  = 0;
      end
      return c;
   endfunction

   // Occupancy model: busy counts the remaining stall-decode cycles
   task automatic model_edge(input bit mext, inout ctl_t e, inout int busy);
      bit   ism;
      ctl_t d;
      if (flush) begin
         e    = '0;
         busy = 0;
      end else if (stall) begin
         busy = busy;
      end else if (busy > 0) begin
         busy--;
      end else begin
         d = ref_decode(instr, valid, mext, ism);
         e = d;
         if (ism && CYC > 1) busy = CYC - 1;
      end
   endtask

   task automatic cycle(input logic [31:0] ins, input logic v, input logic st, input logic fl);
      @(negedge clk);
      instr = ins; valid = v; stall = st; flush = fl;
      #1;
      sd_m = stalld_m;
      sd_i = stalld_i;
      check("stalld_m", 32'(stalld_m), 32'(st || busy_m > 0));
      check("stalld_i", 32'(stalld_i), 32'(st || busy_i > 0));
      @(posedge clk);
      model_edge(1'b1, exp_m, busy_m);
      model_edge(1'b0, exp_i, busy_i);
      #1;
      check("ectl_m", 32'(obs_m), 32'(exp_m));
      check("ectl_i", 32'(obs_i), 32'(exp_i));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
      logic [6:0] f7s[3]  = '{7'h00, 7'h20, 7'h01};
      logic [6:0] op, f7;
      int         k;
      k  = int'($urandom_range(0, 11));
      op = (k < 10) ? ops[k] : 7'($urandom);
      k  = int'($urandom_range(0, 3));
      f7 = (k < 3) ? f7s[k] : 7'($urandom);
      return {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
   endfunction

   localparam logic [31:0] I_ADD = 32'h002081B3;
   localparam logic [31:0] I_SUB = 32'h402081B3;
   localparam logic [31:0] I_BAD = 32'h0000007F;
   localparam logic [31:0] I_MUL = 32'h022081B3;
   localparam logic [31:0] I_NOP = 32'h00000013;

   initial begin
      int n_m, n_i;
      exp_m = '0; exp_i = '0; busy_m = 0; busy_i = 0;
      sd_m = 1'b0; sd_i = 1'b0;

      // reset state
      #3;
      check("rst_ectl_m", 32'(obs_m), 32'h0);
      check("rst_ectl_i", 32'(obs_i), 32'h0);
      check("rst_stalld", 32'({stalld_m, stalld_i}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic R-type and illegal
      cycle(I_ADD, 1'b1, 1'b0, 1'b0);
      check("add_valid", 32'(ve_m), 32'd1);
      check("add_rw", 32'(rw_m), 32'd1);
      check("add_alusrc", 32'(as_m), 32'd0);
      check("add_alu", 32'(alu_m), 32'd0);
      cycle(I_SUB, 1'b1, 1'b0, 1'b0);
      check("sub_alu", 32'(alu_m), 32'd1);
      cycle(I_BAD, 1'b1, 1'b0, 1'b0);
      check("bad_ill", 32'(ill_m), 32'd1);
      check("bad_rw", 32'(rw_m), 32'd0);
      cycle(I_ADD, 1'b0, 1'b0, 1'b0);
      check("bubble", 32'(obs_m), 32'h0);

      // M op: decode holds for exactly CYC-1 cycles, E slot held
      cycle(I_MUL, 1'b1, 1'b0, 1'b0);
      check("mul_alu", 32'(alu_m), 32'd16);
      check("mul_ill_noext", 32'(ill_i), 32'd1);
      n_m = 0; n_i = 0;
      for (int k = 0; k < 6; k++) begin
         cycle(I_NOP, 1'b1, 1'b0, 1'b0);
         if (sd_m) n_m++;
         if (sd_i) n_i++;
         if (k < 3) check("mul_hold", 32'(alu_m), 32'd16);
      end
      check("mul_stall_cycles", 32'(n_m), 32'd3);
      check("noext_stall_cycles", 32'(n_i), 32'd0);

      // flush in the second BUSY cycle
      cycle(I_MUL, 1'b1, 1'b0, 1'b0);
      cycle(I_NOP, 1'b1, 1'b0, 1'b0);
      cycle(I_NOP, 1'b1, 1'b0, 1'b1);
      check("flush_valid", 32'(ve_m), 32'd0);
      cycle(I_ADD, 1'b1, 1'b0, 1'b0);
      check("flush_stalld", 32'(sd_m), 32'd0);

      // stall freezes BUSY counting
      cycle(I_MUL, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(I_NOP, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cycle(I_NOP, 1'b1, 1'b0, 1'b0);

      // asynchronous reset between edges while BUSY
      cycle(I_MUL, 1'b1, 1'b0, 1'b0);
      cycle(I_NOP, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ectl_m", 32'(obs_m), 32'h0);
      check("arst_stalld", 32'(stalld_m), 32'd0);
      exp_m = '0; exp_i = '0; busy_m = 0; busy_i = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(I_ADD, 1'b1, 1'b0, 1'b0);
      check("arst_resume_stalld", 32'(sd_m), 32'd0);
      check("arst_resume_alu", 32'(alu_m), 32'd0);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         cycle(($urandom_range(0, 5) == 0) ? I_MUL : rand_instr(),
               logic'($urandom_range(0, 7) != 0),
               logic'($urandom_range(0, 5) == 0),
               logic'($urandom_range(0, 11) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
